// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered, the result is captured after one EXEC cycle, and the response is held until consumed.
module alu_arbiter #(
    parameter int DATA_W    = 8,
    parameter int OP_W      = 8,
    parameter int CNT_W     = 8,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [OP_W-1:0] OP_DIV = OP_W'(8'h03);
    localparam logic [OP_W-1:0] OP_MOD = OP_W'(8'h13);

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               err_q, err_d;
    logic               rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [CNT_W-1:0]   ops_count_q, ops_count_d;
    logic               grant0, grant1, op_legal, div_zero, rsp_fire;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_grant_q);
            grant1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    always_comb begin
        op_legal = op_q inside {[OP_W'(8'h00):OP_W'(8'h06)], [OP_W'(8'h08):OP_W'(8'h0B)],
                                OP_W'(8'h10), OP_W'(8'h11), OP_W'(8'h13)};
        div_zero = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q == '0);
        rsp_fire = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        err_d        = err_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        ops_count_d  = ops_count_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d     = grant1 ? req1_a  : req0_a;
                    b_d     = grant1 ? req1_b  : req0_b;
                    op_d    = grant1 ? req1_op : req0_op;
                    owner_d = grant1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!op_legal || div_zero) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end else begin
                    result_d = alu_result;
                    err_d    = 1'b0;
                end
                rsp0_valid_d = !owner_q;
                rsp1_valid_d = owner_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_fire) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    last_grant_d = owner_q;
                    ops_count_d  = ops_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= ~PRIO_INIT;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            ops_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            err_q        <= err_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            ops_count_q  <= ops_count_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_err    = err_q;
    assign rsp1_err    = err_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign busy        = (state_q != IDLE);
    assign ops_count   = ops_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU drives alu_result, and a reference model
// predicts arbitration order, results, errors and the completed-operation count.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [7:0] rsp0_result, rsp1_result;
    logic [7:0] alu_a, alu_b, alu_op, alu_result;
    logic       busy;
    logic [7:0] ops_count;

    int checks = 0;
    int passes = 0;

    bit last_served;
    int model_count;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(8), .OP_W(8), .CNT_W(8), .PRIO_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .busy(busy), .ops_count(ops_count)
    );

    // Behavioural ALU; divide/modulo by zero and unknown opcodes return junk the DUT must suppress.
    function automatic logic [7:0] alu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            8'h00: return a + b;
            8'h01: return a - b;
            8'h02: return a * b;
            8'h03: return (b == 8'h00) ? 8'hFF : a / b;
            8'h04: return a & b;
            8'h05: return a | b;
            8'h06: return a ^ b;
            8'h08: return a << b[2:0];
            8'h09: return a >> b[2:0];
            8'h0A: return {6'b0, a > b, a == b};
            8'h0B: return {6'b0, $signed(a) < $signed(b), a < b};
            8'h10: return ~a;
            8'h11: return 8'h00 - a;
            8'h13: return (b == 8'h00) ? 8'hEE : a % b;
            default: return 8'hA5;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    function automatic bit exp_err(input logic [7:0] op, input logic [7:0] b);
        bit legal;
        legal = op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                           8'h08, 8'h09, 8'h0A, 8'h0B, 8'h10, 8'h11, 8'h13};
        return !legal || ((op == 8'h03 || op == 8'h13) && b == 8'h00);
    endfunction

    function automatic logic [7:0] exp_res(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        return exp_err(op, b) ? 8'h00 : alu_fn(op, a, b);
    endfunction

    function automatic int exp_winner(input bit v0, input bit v1);
        if (v0 && v1) return last_served ? 0 : 1;
        return v1 ? 1 : 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Presents the requests, completes whichever is granted and reports what was observed.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] op0,
                          input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] op1,
                          output int winner, output logic [7:0] res, output logic err,
                          output int lat, output bit side_bad, output bit ok);
        ok = 0; side_bad = 0; winner = -1; res = 8'h00; err = 1'b0; lat = 0;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (req0_ready || req1_ready) break;
            @(negedge clk); #1;
        end
        if (!(req0_ready || req1_ready)) return;
        winner = req1_ready ? 1 : 0;
        side_bad = req0_ready && req1_ready;
        @(posedge clk); #1;
        if (winner == 0) begin req0_valid = 0; rsp0_ready = 1; end
        else begin req1_valid = 0; rsp1_ready = 1; end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (winner == 0 ? rsp0_valid : rsp1_valid) begin
                res = (winner == 0) ? rsp0_result : rsp1_result;
                err = (winner == 0) ? rsp0_err : rsp1_err;
                if (winner == 0 ? rsp1_valid : rsp0_valid) side_bad = 1;
                @(posedge clk); #1;
                rsp0_ready = 0; rsp1_ready = 0; ok = 1;
                return;
            end
            if (rsp0_valid || rsp1_valid) side_bad = 1;
        end
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy} !== 7'b0)
            $display("[TB] FAIL reset_flags: got %b want 0000000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy});
        else passes++;
        checks++;
        if ({rsp0_result, rsp1_result} !== 16'h0) $display("[TB] FAIL reset_results: got %h want 0000", {rsp0_result, rsp1_result});
        else passes++;
        checks++;
        if ({alu_a, alu_b, alu_op} !== 24'h0) $display("[TB] FAIL reset_alu: got %h want 000000", {alu_a, alu_b, alu_op});
        else passes++;
        checks++;
        if (ops_count !== 8'h00) $display("[TB] FAIL reset_ops_count: got %h want 00", ops_count);
        else passes++;
    endtask

    task automatic test_basic();
        int w, lat; logic [7:0] res; logic err; bit side, ok;
        do_reset();
        run_op(1, 0, 8'h05, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, w, res, err, lat, side, ok);
        checks++;
        if ({ok, side, w[0]} !== 3'b100) $display("[TB] FAIL basic_handshake: got ok/side/winner %b%b%0d want 1 0 0", ok, side, w);
        else passes++;
        checks++;
        if ({res, err} !== {8'h08, 1'b0}) $display("[TB] FAIL basic_result: got %h err %b want 08 err 0", res, err);
        else passes++;
        checks++;
        if (lat !== 2) $display("[TB] FAIL basic_latency: got %0d want 2", lat);
        else passes++;
        checks++;
        if (ops_count !== 8'h01) $display("[TB] FAIL basic_ops_count: got %h want 01", ops_count);
        else passes++;
    endtask

    task automatic test_tie();
        int w, lat; logic [7:0] res; logic err; bit side, ok;
        do_reset();
        run_op(1, 1, 8'h04, 8'h03, 8'h02, 8'h0A, 8'h03, 8'h01, w, res, err, lat, side, ok);
        checks++;
        if ({ok, side} !== 2'b10 || w !== 0 || res !== 8'h0C)
            $display("[TB] FAIL tie_first: got winner %0d result %h side %b want winner 0 result 0c side 0", w, res, side);
        else passes++;
        run_op(0, 1, 8'h04, 8'h03, 8'h02, 8'h0A, 8'h03, 8'h01, w, res, err, lat, side, ok);
        checks++;
        if (!ok || w !== 1 || res !== 8'h07) $display("[TB] FAIL tie_second: got winner %0d result %h want winner 1 result 07", w, res);
        else passes++;
        run_op(1, 1, 8'h01, 8'h01, 8'h00, 8'h09, 8'h02, 8'h00, w, res, err, lat, side, ok);
        checks++;
        if (!ok || w !== 0 || res !== 8'h02) $display("[TB] FAIL tie_next: got winner %0d result %h want winner 0 result 02", w, res);
        else passes++;
        run_op(0, 1, 8'h01, 8'h01, 8'h00, 8'h09, 8'h02, 8'h00, w, res, err, lat, side, ok);
        checks++;
        if (!ok || w !== 1 || res !== 8'h0B) $display("[TB] FAIL tie_drain: got winner %0d result %h want winner 1 result 0b", w, res);
        else passes++;
    endtask

    task automatic test_div_zero();
        int w, lat; logic [7:0] res; logic err; bit side, ok;
        run_op(1, 0, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, w, res, err, lat, side, ok);
        checks++;
        if (!ok || {res, err} !== {8'h00, 1'b1}) $display("[TB] FAIL div_zero: got %h err %b want 00 err 1", res, err);
        else passes++;
        run_op(0, 1, 8'h00, 8'h00, 8'h00, 8'h11, 8'h05, 8'h13, w, res, err, lat, side, ok);
        checks++;
        if (!ok || {res, err} !== {8'h02, 1'b0}) $display("[TB] FAIL mod_ok: got %h err %b want 02 err 0", res, err);
        else passes++;
    endtask

    task automatic test_backpressure();
        int w, lat; logic [7:0] res; logic err; bit side, ok, seen;
        @(negedge clk);
        req1_valid = 1; req1_a = 8'h20; req1_b = 8'h01; req1_op = 8'h01;
        #1;
        for (int i = 0; i < 8 && !req1_ready; i++) begin @(negedge clk); #1; end
        checks++;
        if (req1_ready !== 1'b1) $display("[TB] FAIL bp_accept: got ready %b want 1", req1_ready);
        else passes++;
        @(posedge clk); #1;
        req1_valid = 0;
        req0_valid = 1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 8'h00;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin @(negedge clk); seen = rsp1_valid; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp1_valid, rsp0_valid, req0_ready, req1_ready, busy} !== 5'b10001 || rsp1_result !== 8'h1F)
                $display("[TB] FAIL bp_hold%0d: got flags %b result %h want 10001 result 1f", i,
                         {rsp1_valid, rsp0_valid, req0_ready, req1_ready, busy}, rsp1_result);
            else passes++;
        end
        rsp1_ready = 1;
        @(posedge clk); #1;
        rsp1_ready = 0;
        run_op(1, 0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, w, res, err, lat, side, ok);
        checks++;
        if (!ok || w !== 0 || res !== 8'h02) $display("[TB] FAIL bp_followup: got winner %0d result %h want winner 0 result 02", w, res);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        req0_valid = 1; req0_a = 8'h09; req0_b = 8'h09; req0_op = 8'h00;
        #1;
        for (int i = 0; i < 8 && !req0_ready; i++) begin @(negedge clk); #1; end
        @(posedge clk); #1;
        req0_valid = 0; rsp0_ready = 1; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy} !== 7'b0 ||
            {rsp0_result, alu_a, alu_b, alu_op, ops_count} !== 40'h0)
            $display("[TB] FAIL midreset_outputs: got flags %b data %h want all zero",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy},
                     {rsp0_result, alu_a, alu_b, alu_op, ops_count});
        else passes++;
        seen = 0;
        repeat (6) begin @(negedge clk); if (rsp0_valid || rsp1_valid) seen = 1; end
        rsp0_ready = 0;
        checks++;
        if (seen || ops_count !== 8'h00) $display("[TB] FAIL midreset_no_rsp: got rsp seen %b ops_count %h want 0 00", seen, ops_count);
        else passes++;
    endtask

    task automatic test_illegal();
        int w, lat; logic [7:0] res; logic err; bit side, ok;
        logic [7:0] bad_ops [4] = '{8'h07, 8'h0C, 8'h12, 8'hFF};
        foreach (bad_ops[i]) begin
            run_op(1, 0, 8'h33, 8'h11, bad_ops[i], 8'h00, 8'h00, 8'h00, w, res, err, lat, side, ok);
            checks++;
            if (!ok || {res, err} !== {8'h00, 1'b1})
                $display("[TB] FAIL illegal_op_%h: got %h err %b want 00 err 1", bad_ops[i], res, err);
            else passes++;
        end
    endtask

    task automatic test_random();
        int w, lat, ew; logic [7:0] res; logic err; bit side, ok;
        bit pend [2];
        logic [7:0] pa [2], pb [2], pop [2];
        logic [7:0] op_tab [18] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h09,
                                    8'h0A, 8'h0B, 8'h10, 8'h11, 8'h13, 8'h07, 8'h0E, 8'h14, 8'h03};
        do_reset();
        last_served = 1'b1;
        model_count = 0;
        pend[0] = 0; pend[1] = 0;
        for (int it = 0; it < 40; it++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && ($urandom_range(0, 1) == 1 || (n == 1 && !pend[0]))) begin
                    pend[n] = 1;
                    pa[n]   = 8'($urandom);
                    pb[n]   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                    pop[n]  = op_tab[$urandom_range(0, 17)];
                end
            end
            ew = exp_winner(pend[0], pend[1]);
            run_op(pend[0], pend[1], pa[0], pb[0], pop[0], pa[1], pb[1], pop[1], w, res, err, lat, side, ok);
            checks++;
            if (!ok || side || w !== ew || lat !== 2)
                $display("[TB] FAIL rand%0d_grant: got ok %b side %b winner %0d lat %0d want 1 0 %0d 2", it, ok, side, w, lat, ew);
            else passes++;
            checks++;
            if ({res, err} !== {exp_res(pop[ew], pa[ew], pb[ew]), exp_err(pop[ew], pb[ew])})
                $display("[TB] FAIL rand%0d_result: op %h a %h b %h got %h err %b want %h err %b", it, pop[ew], pa[ew], pb[ew],
                         res, err, exp_res(pop[ew], pa[ew], pb[ew]), exp_err(pop[ew], pb[ew]));
            else passes++;
            pend[ew] = 0;
            last_served = ew[0];
            model_count++;
            checks++;
            if (ops_count !== 8'(model_count)) $display("[TB] FAIL rand%0d_count: got %h want %h", it, ops_count, 8'(model_count));
            else passes++;
        end
    endtask

    task automatic test_wrap();
        int w, lat, bad; logic [7:0] res; logic err; bit side, ok;
        do_reset();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            run_op(1, 0, 8'(i), 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, w, res, err, lat, side, ok);
            if (!ok || res !== 8'(i + 1)) bad++;
            if (i == 254) begin
                checks++;
                if (ops_count !== 8'hFF) $display("[TB] FAIL wrap_max: got %h want ff", ops_count);
                else passes++;
            end
        end
        checks++;
        if (ops_count !== 8'h00) $display("[TB] FAIL wrap_zero: got %h want 00", ops_count);
        else passes++;
        checks++;
        if (bad !== 0) $display("[TB] FAIL wrap_ops: got %0d bad ops want 0", bad);
        else passes++;
    endtask

    initial begin
        rst = 1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        test_reset();
        test_basic();
        test_tie();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_illegal();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
